// File: rtl/approx_dot_accumulator.sv
// Dot-product accumulator placed after the 8x8 approximate multiplier.
// Sums VEC_LEN unsigned 16-bit products per vector and presents each completed
// sum in a one-entry output register with valid/ready backpressure.
module approx_dot_accumulator #(
   parameter int unsigned VEC_LEN = 16,
   parameter int unsigned ACC_W   = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [7:0]       out_vec_id
);

   localparam int unsigned CNT_W = $clog2(VEC_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

   // Reject parameter sets that could wrap the accumulator or the counter.
   if (ACC_W < 16 + $clog2(VEC_LEN)) begin : g_acc_w_check
      $error("approx_dot_accumulator: ACC_W too narrow for VEC_LEN");
   end
   if (VEC_LEN < 2 || VEC_LEN > 255) begin : g_vec_len_check
      $error("approx_dot_accumulator: VEC_LEN outside 2..255");
   end

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       vec_cnt;

   logic             is_last;
   logic             accept;
   logic             complete;
   logic [ACC_W-1:0] sum_next;

   // Handshake decode; in_ready never looks at in_valid or clr.
   always_comb begin
      is_last  = (cnt == LAST);
      in_ready = !(out_valid && !out_ready && is_last);
      accept   = in_valid && in_ready;
      complete = accept && is_last && !clr;
      sum_next = acc + ACC_W'(in_prod);
   end

   // Partial-vector accumulator and product counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (clr) begin
         // A product offered alongside clr is dropped.
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         if (is_last) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= sum_next;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Output register; a completing accept reloads it even while draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_sum    <= '0;
         out_vec_id <= '0;
         vec_cnt    <= '0;
      end else if (complete) begin
         out_valid  <= 1'b1;
         out_sum    <= sum_next;
         out_vec_id <= vec_cnt;
         vec_cnt    <= vec_cnt + 8'd1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_approx_dot_accumulator.sv
// Self-checking bench for approx_dot_accumulator: directed scenarios from the
// intended use plus a randomized run, all checked against a queue-based model.
module tb_approx_dot_accumulator;

   localparam int unsigned VEC_LEN = 4;
   localparam int unsigned ACC_W   = 18;

   logic             clk = 1'b0;
   logic             rst;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_prod;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [7:0]       out_vec_id;

   approx_dot_accumulator #(
      .VEC_LEN(VEC_LEN),
      .ACC_W  (ACC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_vec_id(out_vec_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: products of the current vector, plus the output register.
   int unsigned part[$];
   bit          m_valid;
   int unsigned m_sum;
   int unsigned m_id;
   int unsigned m_vec;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      part.delete();
      m_valid = 1'b0;
      m_sum   = 0;
      m_id    = 0;
      m_vec   = 0;
   endtask

   // One clock cycle: drive at negedge, check in_ready, model the edge, check outputs.
   task automatic cycle(input bit v, input int unsigned p, input bit r, input bit c,
                        input bit rs);
      bit          exp_ready;
      bit          comp;
      int unsigned s;
      @(negedge clk);
      in_valid  = v;
      in_prod   = 16'(p);
      out_ready = r;
      clr       = c;
      rst       = rs;
      #1;
      exp_ready = !(m_valid && !r && part.size() == VEC_LEN - 1);
      if (!rs) check("in_ready", in_ready, exp_ready);
      @(posedge clk);
      if (rs) begin
         model_reset();
      end else begin
         comp = 1'b0;
         s    = 0;
         if (c) begin
            part.delete();
         end else if (v && exp_ready) begin
            part.push_back(p);
            if (part.size() == VEC_LEN) begin
               foreach (part[i]) s += part[i];
               part.delete();
               comp = 1'b1;
            end
         end
         if (comp) begin
            m_valid = 1'b1;
            m_sum   = s;
            m_id    = m_vec;
            m_vec   = (m_vec + 1) % 256;
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
      end
      #1;
      check("out_valid", out_valid, m_valid);
      check("out_sum", out_sum, m_sum);
      check("out_vec_id", out_vec_id, m_id);
   endtask

   initial begin
      rst       = 1'b1;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_prod   = '0;
      out_ready = 1'b0;
      model_reset();

      // Reset
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_vec_id", out_vec_id, 0);
      check("rst_in_ready", in_ready, 1);

      // Basic sum 1+2+3+4
      for (int i = 1; i <= 4; i++) cycle(1, i, 1, 0, 0);
      check("basic_valid", out_valid, 1);
      check("basic_sum", out_sum, 10);
      check("basic_id", out_vec_id, 0);

      // Max-value products
      for (int i = 0; i < 4; i++) cycle(1, 65025, 1, 0, 0);
      check("max_sum", out_sum, 260100);
      cycle(0, 0, 1, 0, 0);
      check("max_drained", out_valid, 0);

      // Backpressure: first result held, completing product stalls
      for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0, 0);
      for (int i = 5; i <= 7; i++) cycle(1, i, 0, 0, 0);
      check("bp_held_sum", out_sum, 10);
      cycle(1, 8, 0, 0, 0);
      cycle(1, 8, 0, 0, 0);
      check("bp_still_held", out_sum, 10);
      cycle(1, 8, 1, 0, 0);
      check("bp_next_valid", out_valid, 1);
      check("bp_next_sum", out_sum, 26);
      check("bp_next_id", out_vec_id, 3);
      cycle(0, 0, 1, 0, 0);

      // Back-to-back vectors of 100
      for (int i = 0; i < 12; i++) begin
         cycle(1, 100, 1, 0, 0);
         if (i % 4 == 3) check("b2b_sum", out_sum, 400);
      end

      // Clear: held output untouched, product with clr dropped
      cycle(1, 7, 0, 0, 0);
      cycle(1, 7, 0, 0, 0);
      cycle(1, 9, 0, 1, 0);
      check("clr_held_sum", out_sum, 400);
      check("clr_held_valid", out_valid, 1);
      for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0);
      check("clr_sum", out_sum, 4);

      // Reset with a partial vector and pending output
      cycle(1, 5, 0, 0, 0);
      cycle(1, 6, 0, 0, 0);
      cycle(1, 9, 0, 0, 1);
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_sum", out_sum, 0);
      for (int i = 1; i <= 4; i++) cycle(1, i, 1, 0, 0);
      check("rst_mid_next_sum", out_sum, 10);
      check("rst_mid_next_id", out_vec_id, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 65535),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 99) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/approx_dot_accumulator.md
# approx_dot_accumulator

Downstream consumer of the unsigned 8x8 approximate multipliers: accepts one 16-bit product per handshake and sums fixed-length vectors of products into a dot-product result. It sits directly after the multiplier output `z` in the evaluation datapath. It emits each completed sum through a one-entry output register with valid/ready backpressure. The accumulator is sized so sums never overflow.

## Interface
- `VEC_LEN`, default 16: products per vector; legal range 2..255.
- `ACC_W`, default 20: accumulator and result width; must be ≥ 16 + clog2(VEC_LEN). Violation is an elaboration error.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clr` in 1: synchronous discard of the partial vector.
- `in_valid` in 1: `in_prod` is valid.
- `in_ready` out 1: block can accept a product this cycle.
- `in_prod` in 16: unsigned product from the multiplier.
- `out_valid` out 1: `out_sum` holds a completed vector sum.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out ACC_W: unsigned sum of `VEC_LEN` products.
- `out_vec_id` out 8: index of the emitted vector, wraps 255→0.

## Operation
- **Internal state:**
  - `acc` (ACC_W bits)
  - `cnt` (clog2(VEC_LEN) bits): products already in `acc`
  - output register: `out_sum`, `out_valid`, `out_vec_id`
  - `vec_cnt` (8 bits): id of the next vector to emit
- **Accept:** a product is accepted when `in_valid && in_ready` at a rising edge.
- **Non-completing accept** (`cnt < VEC_LEN-1`): `acc <= acc + in_prod` (zero-extended), `cnt <= cnt + 1`.
- **Completing accept** (`cnt == VEC_LEN-1`):
  - `out_sum <= acc + in_prod`, `out_valid <= 1`, `out_vec_id <= vec_cnt`.
  - `vec_cnt <= vec_cnt + 1`.
  - `acc <= 0`, `cnt <= 0`.
- **Output drain:** when `out_valid && out_ready`, `out_valid <= 0` unless a completing accept happens in the same cycle. In that case the output register reloads with the new sum and `out_valid` stays 1.
- **Backpressure:** `in_ready = !(out_valid && !out_ready && cnt == VEC_LEN-1)`. Non-completing products keep flowing while a result is held. Only the completing product stalls.
  - `in_ready` depends combinationally on `out_ready` and registered state only, never on `in_valid`.
- **`clr`:**
  - Sets `acc <= 0`, `cnt <= 0` and drops any product accepted in the same cycle.
  - Does not touch the output register or `vec_cnt`.
  - `in_ready` is unaffected by `clr`.
- **Arithmetic:** unsigned throughout. The width rule guarantees no wrap, so no saturation logic exists.
- **Stability:** while `out_valid && !out_ready`, `out_sum` and `out_vec_id` hold stable.

## Timing
- **Reset values:** `acc=0`, `cnt=0`, `vec_cnt=0`, `out_valid=0`, `out_sum=0`, `out_vec_id=0`. `in_ready` reads 1 during and after reset.
- **`rst` priority:** `rst` overrides `clr` and any handshake in the same cycle. Reset mid-vector discards the partial sum and any pending output.
- **Latency:** the completing product accepted at edge t gives `out_valid=1` with its sum after edge t, visible in cycle t+1.
- **Throughput:** one product per cycle sustained when `out_ready` is held high. There are no bubbles between vectors.
- **Simultaneous drain and complete:** accepted in the same cycle with no lost or duplicated result.
- **Held output:** `out_valid` is never deasserted without `out_ready` sampled high.

## Test plan
- **Basic sum:** `VEC_LEN=4`, `out_ready=1`, products 1,2,3,4 on consecutive cycles → one cycle after the 4th accept, `out_valid=1`, `out_sum=10`, `out_vec_id=0`; `in_ready` stays 1 throughout.
- **Max-value width check:** `VEC_LEN=4`, `ACC_W=18`, four products of 65025 → `out_sum=260100`, no overflow.
- **Backpressure:**
  - `VEC_LEN=4`, `out_ready=0`; stream 1..4, then 5,6,7,8 → first result (`out_sum=10`) holds.
  - 5,6,7 are accepted; `in_ready=0` while 8 is offered.
  - Raise `out_ready` → 10 drains, 8 is accepted, next result is 26 with `out_vec_id=1`.
- **Back-to-back:** `out_ready=1`, 12 continuous products of value 100, `VEC_LEN=4` → `out_valid` pulses each 4th cycle+1 with `out_sum=400` and ids 0,1,2; `in_ready` never drops.
- **Clear:** `VEC_LEN=4`, accept 7,7; assert `clr` together with product 9; then accept 1,1,1,1 → `out_sum=4`; the held previous output is unaffected.
- **Reset mid-operation:** two products accepted and a result pending with `out_ready=0`; assert `rst` one cycle → `out_valid=0`, `out_sum=0`. The next vector reports `out_vec_id=0` with only post-reset products summed.
